// File: rtl/mem2_writeback_buffer_if.sv
// mem2_writeback_buffer_if: MEM2 capture, RF write port and forwarding signals of the write-back buffer
interface mem2_writeback_buffer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int REG_INDEX_BITS = 5,
   parameter int THREAD_INDEX_BITS = 3,
   parameter int DEPTH = 4
);
   logic                         in_write_back_flag;
   logic [REG_INDEX_BITS-1:0]    in_reg_index;
   logic [THREAD_INDEX_BITS-1:0] in_thread_index;
   logic [DATA_WIDTH-1:0]        in_data;
   logic                         out_stall;
   logic                         rf_wr_en;
   logic [THREAD_INDEX_BITS-1:0] rf_wr_thread;
   logic [REG_INDEX_BITS-1:0]    rf_wr_index;
   logic [DATA_WIDTH-1:0]        rf_wr_data;
   logic                         rf_wr_grant;
   logic [THREAD_INDEX_BITS-1:0] fwd_thread;
   logic [REG_INDEX_BITS-1:0]    fwd_reg_index;
   logic                         fwd_hit;
   logic [DATA_WIDTH-1:0]        fwd_data;
   logic [$clog2(DEPTH):0]       occupancy;
   logic                         overflow_err;
   modport master (
      output in_write_back_flag, in_reg_index, in_thread_index, in_data,
             rf_wr_grant, fwd_thread, fwd_reg_index,
      input  out_stall, rf_wr_en, rf_wr_thread, rf_wr_index, rf_wr_data,
             fwd_hit, fwd_data, occupancy, overflow_err
   );
   modport slave (
      input  in_write_back_flag, in_reg_index, in_thread_index, in_data,
             rf_wr_grant, fwd_thread, fwd_reg_index,
      output out_stall, rf_wr_en, rf_wr_thread, rf_wr_index, rf_wr_data,
             fwd_hit, fwd_data, occupancy, overflow_err
   );
endinterface

// File: rtl/mem2_writeback_buffer.sv
// mem2_writeback_buffer: in-order write-back FIFO draining to the RF port, with newest-first forwarding
module mem2_writeback_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int REG_INDEX_BITS = 5,
   parameter int THREAD_INDEX_BITS = 3,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic reset,
   mem2_writeback_buffer_if.slave wb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [THREAD_INDEX_BITS-1:0] thread_q [DEPTH];
   logic [REG_INDEX_BITS-1:0]    reg_q [DEPTH];
   logic [DATA_WIDTH-1:0]        data_q [DEPTH];
   logic [PW-1:0]                wr_ptr, rd_ptr, idx;
   logic [CW-1:0]                occ;
   logic                         ovf, push, pop, full, accept, hit;
   logic [DATA_WIDTH-1:0]        hit_data;
   assign push = wb.in_write_back_flag && wb.in_reg_index != '0;
   assign full = occ == CW'(DEPTH);
   assign pop = wb.rf_wr_en && wb.rf_wr_grant;
   // a same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign accept = push && (!full || pop);
   assign wb.rf_wr_en = occ != '0;
   assign wb.rf_wr_thread = thread_q[rd_ptr];
   assign wb.rf_wr_index = reg_q[rd_ptr];
   assign wb.rf_wr_data = data_q[rd_ptr];
   assign wb.out_stall = occ >= CW'(DEPTH - 1);
   assign wb.occupancy = occ;
   assign wb.overflow_err = ovf;
   assign wb.fwd_hit = hit;
   assign wb.fwd_data = hit_data;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ <= '0;
         ovf <= 1'b0;
      end else begin
         wr_ptr <= accept ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         occ <= occ + CW'(accept) - CW'(pop);
         ovf <= ovf || (push && full && !pop);
      end
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         thread_q[wr_ptr] <= wb.in_thread_index;
         reg_q[wr_ptr] <= wb.in_reg_index;
         data_q[wr_ptr] <= wb.in_data;
      end
   end
   // scan oldest to newest so later matches override; r0 is never stored, so a r0 query cannot hit
   always_comb begin
      hit = 1'b0;
      hit_data = '0;
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (CW'(i) < occ && thread_q[idx] == wb.fwd_thread && reg_q[idx] == wb.fwd_reg_index) begin
            hit = 1'b1;
            hit_data = data_q[idx];
         end
      end
      if (push && wb.in_thread_index == wb.fwd_thread && wb.in_reg_index == wb.fwd_reg_index) begin
         hit = 1'b1;
         hit_data = wb.in_data;
      end
   end
endmodule
